// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU execute stage.
//   - ALU operation codes (ealuc encoding)
//   - squash state machine encoding
//   - bounds of the shift-amount field inside the sign-extended immediate
package cpu_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0001;  // also BEQ
  localparam logic [3:0] ALUC_AND = 4'b0010;
  localparam logic [3:0] ALUC_OR  = 4'b0011;
  localparam logic [3:0] ALUC_XOR = 4'b0100;
  localparam logic [3:0] ALUC_NOR = 4'b0101;
  localparam logic [3:0] ALUC_SLT = 4'b0110;
  localparam logic [3:0] ALUC_LUI = 4'b0111;
  localparam logic [3:0] ALUC_SLL = 4'b1000;
  localparam logic [3:0] ALUC_SRL = 4'b1001;
  localparam logic [3:0] ALUC_SRA = 4'b1010;
  localparam logic [3:0] ALUC_BNE = 4'b1111;  // computes SUB

  // RUN, or SQ(k) with k = remaining wrong-path slots to squash
  typedef enum logic [1:0] {
    SQ_RUN = 2'd0,
    SQ_1   = 2'd1,
    SQ_2   = 2'd2,
    SQ_3   = 2'd3
  } sq_state_e;

  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;

endpackage

// File: rtl/exe_stage_alu.sv
// alu: purely combinational ALU, reusable outside the execute stage.
// Ports:
//   a, b    in  W : operands (a[4:0] is the shift amount for shifts)
//   aluc    in  4 : operation code (cpu_pkg ALUC_*)
//   result  out W : operation result, wraps mod 2^W
//   zero    out 1 : result == 0
module alu
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   aluc,
  output logic [W-1:0] result,
  output logic         zero
);

  // Operation select; unknown codes produce zero
  always_comb begin
    result = '0;
    case (aluc)
      ALUC_ADD:           result = a + b;
      ALUC_SUB, ALUC_BNE: result = a - b;
      ALUC_AND:           result = a & b;
      ALUC_OR:            result = a | b;
      ALUC_XOR:           result = a ^ b;
      ALUC_NOR:           result = ~(a | b);
      ALUC_SLT:           result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUC_LUI:           result = b << 5'd16;
      ALUC_SLL:           result = b << a[4:0];
      ALUC_SRL:           result = b >> a[4:0];
      ALUC_SRA:           result = $signed(b) >>> a[4:0];
      default:            result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage pipeline.
// Selects ALU operands, resolves conditional branches (combinational redirect),
// squashes the SQUASH_N wrong-path instructions that follow a taken branch,
// and registers results into the EXE/MEM boundary.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ewreg/em2reg/ewmem/eshift/ealuimm, ealuc   control from ID/EXE
//   odata_a/odata_b/odata_imm        operands and sign-extended immediate
//   e_branch, e_pc4                  branch flag and PC+4
//   e_regrt, e_rt, e_rd              destination register select
//   EXE_ins_type/EXE_ins_number      trace tags
//   br_taken, br_target              combinational PC redirect
//   m_*, MEM_*                       registered EXE/MEM outputs
module exe_stage
  import cpu_pkg::*;
#(
  parameter int W        = 32,
  parameter int SQUASH_N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ewreg,
  input  logic         em2reg,
  input  logic         ewmem,
  input  logic         eshift,
  input  logic         ealuimm,
  input  logic [3:0]   ealuc,
  input  logic [W-1:0] odata_a,
  input  logic [W-1:0] odata_b,
  input  logic [W-1:0] odata_imm,
  input  logic         e_branch,
  input  logic [W-1:0] e_pc4,
  input  logic         e_regrt,
  input  logic [4:0]   e_rt,
  input  logic [4:0]   e_rd,
  input  logic [3:0]   EXE_ins_type,
  input  logic [3:0]   EXE_ins_number,
  output logic         br_taken,
  output logic [W-1:0] br_target,
  output logic         m_valid,
  output logic         m_wreg,
  output logic         m_m2reg,
  output logic         m_wmem,
  output logic [W-1:0] m_alu,
  output logic [W-1:0] m_data_b,
  output logic [4:0]   m_rd,
  output logic [3:0]   MEM_ins_type,
  output logic [3:0]   MEM_ins_number
);

  localparam sq_state_e SQ_START = sq_state_e'(2'(SQUASH_N));

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         cond;
  logic         squash;
  sq_state_e    state_q;
  sq_state_e    state_d;

  // Shift instructions take their amount from the immediate's shamt field
  assign alu_a = eshift ? {{(W-5){1'b0}}, odata_imm[SHAMT_MSB:SHAMT_LSB]} : odata_a;
  assign alu_b = ealuimm ? odata_imm : odata_b;

  alu #(.W(W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .aluc   (ealuc),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Branch condition from the ALU zero flag
  always_comb begin
    cond = 1'b0;
    case (ealuc)
      ALUC_SUB: cond = alu_zero;
      ALUC_BNE: cond = ~alu_zero;
      default:  cond = 1'b0;
    endcase
  end

  assign squash    = (state_q != SQ_RUN);
  // rst_n gating keeps the redirect quiet while the pipeline is held in reset
  assign br_taken  = rst_n & e_branch & cond & ~squash;
  assign br_target = e_pc4 + (odata_imm << 2'd2);

  // Squash sequencer: once started it counts down unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_RUN: begin
        if (br_taken) state_d = SQ_START;
        else          state_d = SQ_RUN;
      end
      SQ_3:    state_d = SQ_2;
      SQ_2:    state_d = SQ_1;
      SQ_1:    state_d = SQ_RUN;
      default: state_d = SQ_RUN;
    endcase
  end

  // Squash state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SQ_RUN;
    else        state_q <= state_d;
  end

  // EXE/MEM register; squashed slots keep datapath values for debug only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid        <= 1'b0;
      m_wreg         <= 1'b0;
      m_m2reg        <= 1'b0;
      m_wmem         <= 1'b0;
      m_alu          <= '0;
      m_data_b       <= '0;
      m_rd           <= 5'd0;
      MEM_ins_type   <= 4'd0;
      MEM_ins_number <= 4'd0;
    end else begin
      m_valid        <= ~squash;
      m_wreg         <= ewreg & ~squash;
      m_m2reg        <= em2reg & ~squash;
      m_wmem         <= ewmem & ~squash;
      m_alu          <= alu_result;
      m_data_b       <= odata_b;
      m_rd           <= e_regrt ? e_rt : e_rd;
      MEM_ins_type   <= EXE_ins_type;
      MEM_ins_number <= EXE_ins_number;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  localparam int W        = 32;
  localparam int SQUASH_N = 2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ewreg, em2reg, ewmem, eshift, ealuimm;
  logic [3:0]   ealuc;
  logic [W-1:0] odata_a, odata_b, odata_imm;
  logic         e_branch;
  logic [W-1:0] e_pc4;
  logic         e_regrt;
  logic [4:0]   e_rt, e_rd;
  logic [3:0]   EXE_ins_type, EXE_ins_number;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         m_valid, m_wreg, m_m2reg, m_wmem;
  logic [W-1:0] m_alu, m_data_b;
  logic [4:0]   m_rd;
  logic [3:0]   MEM_ins_type, MEM_ins_number;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exe_stage #(.W(W), .SQUASH_N(SQUASH_N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ewreg          (ewreg),
    .em2reg         (em2reg),
    .ewmem          (ewmem),
    .eshift         (eshift),
    .ealuimm        (ealuimm),
    .ealuc          (ealuc),
    .odata_a        (odata_a),
    .odata_b        (odata_b),
    .odata_imm      (odata_imm),
    .e_branch       (e_branch),
    .e_pc4          (e_pc4),
    .e_regrt        (e_regrt),
    .e_rt           (e_rt),
    .e_rd           (e_rd),
    .EXE_ins_type   (EXE_ins_type),
    .EXE_ins_number (EXE_ins_number),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .m_valid        (m_valid),
    .m_wreg         (m_wreg),
    .m_m2reg        (m_m2reg),
    .m_wmem         (m_wmem),
    .m_alu          (m_alu),
    .m_data_b       (m_data_b),
    .m_rd           (m_rd),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic shift, input logic aluimm);
    ealuc     = aluc;
    odata_a   = a;
    odata_b   = b;
    odata_imm = imm;
    eshift    = shift;
    ealuimm   = aluimm;
  endtask

  task automatic set_ctl(input logic wreg, input logic m2reg, input logic wmem, input logic branch);
    ewreg    = wreg;
    em2reg   = m2reg;
    ewmem    = wmem;
    e_branch = branch;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_op(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    tick();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_wreg !== 1'b0) $display("FAIL rst_m_wreg: got %b want 0", m_wreg); else pass_cnt++;
    total_cnt++; if (m_alu !== 32'h0) $display("FAIL rst_m_alu: got %h want 0", m_alu); else pass_cnt++;
    // a taken-looking BEQ must not redirect while reset is held
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_SUB, 32'd5, 32'd5, 32'd4, 1'b0, 1'b0);
    #1;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL rst_br_taken: got %b want 0", br_taken); else pass_cnt++;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_op(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL rel_m_valid: got %b want 1", m_valid); else pass_cnt++;
    total_cnt++; if (m_wreg !== 1'b1) $display("FAIL rel_m_wreg: got %b want 1", m_wreg); else pass_cnt++;
    total_cnt++; if (m_alu !== 32'd3) $display("FAIL rel_m_alu: got %h want 3", m_alu); else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [3:0]  v_op  [0:12] = '{OP_ADD, OP_SLT, OP_SLT, OP_SRA, OP_LUI, OP_SUB, OP_AND,
                                  OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, 4'b1011};
    logic [31:0] v_a   [0:12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5,
                                  32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] v_b   [0:12] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd7,
                                  32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd0,
                                  32'd1, 32'h8000_0000, 32'd5};
    logic [31:0] v_imm [0:12] = '{32'd0, 32'd0, 32'd0, 32'h0000_0100, 32'h0000_1234, 32'd0,
                                  32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_00C0, 32'h0000_0100, 32'd0};
    logic        v_sh  [0:12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b0};
    logic        v_im  [0:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0};
    logic [31:0] v_exp [0:12] = '{32'h0, 32'd1, 32'd0, 32'hF800_0000, 32'h1234_0000, 32'hFFFF_FFFE,
                                  32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'hFFFF_FFFF,
                                  32'd8, 32'h0800_0000, 32'h0};
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      set_op(v_op[i], v_a[i], v_b[i], v_imm[i], v_sh[i], v_im[i]);
      tick();
      total_cnt++;
      if (m_alu !== v_exp[i]) $display("FAIL alu_vec%0d: got %h want %h", i, m_alu, v_exp[i]);
      else pass_cnt++;
    end
    // destination select, store data, trace tags and memory controls
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
    set_op(OP_ADD, 32'd10, 32'hDEAD_BEEF, 32'd4, 1'b0, 1'b1);
    e_regrt = 1'b1; e_rt = 5'd7; e_rd = 5'd9;
    EXE_ins_type = 4'd3; EXE_ins_number = 4'd5;
    tick();
    total_cnt++; if (m_alu !== 32'd14) $display("FAIL aluimm_add: got %h want e", m_alu); else pass_cnt++;
    total_cnt++; if (m_data_b !== 32'hDEAD_BEEF) $display("FAIL data_b: got %h want deadbeef", m_data_b); else pass_cnt++;
    total_cnt++; if (m_rd !== 5'd7) $display("FAIL rd_rt: got %0d want 7", m_rd); else pass_cnt++;
    total_cnt++; if ({m_m2reg, m_wmem, m_wreg} !== 3'b110) $display("FAIL mem_ctl: got %b want 110", {m_m2reg, m_wmem, m_wreg}); else pass_cnt++;
    total_cnt++; if ({MEM_ins_type, MEM_ins_number} !== 8'h35) $display("FAIL tags: got %h want 35", {MEM_ins_type, MEM_ins_number}); else pass_cnt++;
    e_regrt = 1'b0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total_cnt++; if (m_rd !== 5'd9) $display("FAIL rd_rd: got %0d want 9", m_rd); else pass_cnt++;
  endtask

  task automatic test_beq_taken();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_SUB, 32'd5, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    e_pc4 = 32'h100;
    #1;
    total_cnt++; if (br_taken !== 1'b1) $display("FAIL beq_taken: got %b want 1", br_taken); else pass_cnt++;
    total_cnt++; if (br_target !== 32'hF8) $display("FAIL beq_target: got %h want f8", br_target); else pass_cnt++;
    tick();
    total_cnt++; if (m_valid !== 1'b1 || m_wreg !== 1'b0) $display("FAIL beq_reg: got valid=%b wreg=%b want 1/0", m_valid, m_wreg); else pass_cnt++;
    for (int s = 0; s < SQUASH_N; s++) begin
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (m_valid !== 1'b0 || m_wreg !== 1'b0) $display("FAIL squash_slot%0d: got valid=%b wreg=%b want 0/0", s, m_valid, m_wreg);
      else pass_cnt++;
    end
    tick();
    total_cnt++; if (m_valid !== 1'b1 || m_wreg !== 1'b1) $display("FAIL post_squash: got valid=%b wreg=%b want 1/1", m_valid, m_wreg); else pass_cnt++;
  endtask

  task automatic test_bne();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_BNE, 32'd9, 32'd9, 32'd8, 1'b0, 1'b0);
    e_pc4 = 32'h40;
    #1;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL bne_eq: got %b want 0", br_taken); else pass_cnt++;
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_op(OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
    tick();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL bne_no_squash: got %b want 1", m_valid); else pass_cnt++;
    // BNE taken, and a non-branch whose ALU says "equal" must not redirect
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_BNE, 32'd9, 32'd3, 32'd8, 1'b0, 1'b0);
    #1;
    total_cnt++; if (br_taken !== 1'b1 || br_target !== 32'h60) $display("FAIL bne_ne: got %b/%h want 1/60", br_taken, br_target); else pass_cnt++;
    e_branch = 1'b0;
    set_op(OP_SUB, 32'd3, 32'd3, 32'd8, 1'b0, 1'b0);
    #1;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL nonbranch_eq: got %b want 0", br_taken); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_SUB, 32'd1, 32'd1, 32'd4, 1'b0, 1'b0);
    e_pc4 = 32'h200;
    #1;
    total_cnt++; if (br_taken !== 1'b1 || br_target !== 32'h210) $display("FAIL b2b_first: got %b/%h want 1/210", br_taken, br_target); else pass_cnt++;
    tick();
    for (int s = 0; s < SQUASH_N; s++) begin
      #1;
      total_cnt++;
      if (br_taken !== 1'b0) $display("FAIL b2b_slot%0d_br: got %b want 0", s, br_taken); else pass_cnt++;
      tick();
      total_cnt++;
      if (m_valid !== 1'b0) $display("FAIL b2b_slot%0d_valid: got %b want 0", s, m_valid); else pass_cnt++;
    end
    // back in RUN after exactly SQUASH_N slots: the same branch redirects again
    #1;
    total_cnt++; if (br_taken !== 1'b1) $display("FAIL b2b_rerun: got %b want 1", br_taken); else pass_cnt++;
    tick();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL b2b_rerun_valid: got %b want 1", m_valid); else pass_cnt++;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (SQUASH_N) tick();
  endtask

  task automatic test_reset_mid_squash();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_op(OP_SUB, 32'd6, 32'd6, 32'd1, 1'b0, 1'b0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_op(OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
    tick();
    // now in SQ(1): the squashed ADD left m_alu = 7
    total_cnt++; if (m_alu !== 32'd7 || m_valid !== 1'b0) $display("FAIL sq1_state: got alu=%h valid=%b want 7/0", m_alu, m_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (m_alu !== 32'h0) $display("FAIL async_rst_alu: got %h want 0", m_alu); else pass_cnt++;
    tick();
    set_op(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (m_valid !== 1'b1 || m_wreg !== 1'b1) $display("FAIL rst_mid_first: got valid=%b wreg=%b want 1/1", m_valid, m_wreg); else pass_cnt++;
    total_cnt++; if (m_alu !== 32'd30) $display("FAIL rst_mid_alu: got %h want 1e", m_alu); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_op(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    e_pc4 = 32'd0; e_regrt = 1'b0; e_rt = 5'd0; e_rd = 5'd0;
    EXE_ins_type = 4'd0; EXE_ins_number = 4'd0;
    repeat (2) tick();
    test_reset();
    test_alu();
    test_beq_taken();
    test_bne();
    test_back_to_back();
    test_reset_mid_squash();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipelined CPU: consumes the ID/EXE pipeline-register outputs, performs the ALU operation and resolves branches, and registers results into the EXE/MEM boundary. Control hazards are handled here with a squash state machine. After a taken branch, the two younger (wrongly fetched) instructions reaching EXE are converted to bubbles. A redirect is issued to the PC. No upstream register flush is needed.

## Interface
- `W`, default 32: datapath width.
- `SQUASH_N`, default 2: number of wrong-path slots squashed after a taken branch (1..3).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ewreg, em2reg, ewmem, eshift, ealuimm`  in  1 each: control from ID/EXE.
- `ealuc`  in  4: ALU op.
- `odata_a, odata_b, odata_imm`  in  W: operands and sign-extended immediate.
- `e_branch`  in  1: instruction is a conditional branch.
- `e_pc4`  in  W: PC+4 of the EXE instruction.
- `e_regrt`  in  1: destination select; 1 selects `e_rt`, 0 selects `e_rd`.
- `e_rt, e_rd`  in  5: register numbers.
- `EXE_ins_type, EXE_ins_number`  in  4 each: trace tags.
- `br_taken`  out  1: redirect PC this cycle (combinational).
- `br_target`  out  W: `e_pc4 + (odata_imm << 2)`, mod 2^W.
- `m_valid`  out  1: registered; MEM-stage instruction is not a bubble.
- `m_wreg, m_m2reg, m_wmem`  out  1: registered control.
- `m_alu, m_data_b`  out  W: registered ALU result and store data.
- `m_rd`  out  5: registered destination register.
- `MEM_ins_type, MEM_ins_number`  out  4: registered trace tags.

## Operation
- ALU operand A is `{27'b0, odata_imm[10:6]}` when `eshift`, else `odata_a`. Operand B is `odata_imm` when `ealuimm`, else `odata_b`.
- `ealuc` encoding:
  - 0000 ADD
  - 0001 SUB/BEQ
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOR
  - 0110 SLT (signed, result 0/1)
  - 0111 LUI (`B << 16`)
  - 1000 SLL (`B << A[4:0]`)
  - 1001 SRL
  - 1010 SRA
  - 1111 BNE (computes SUB)
  - Any other code yields 0.
- Arithmetic wraps mod 2^W and no overflow trap exists. `zero = (result == 0)`.
- Branch condition: `cond = zero` for SUB/BEQ, `cond = !zero` for BNE, 0 for all other codes.
- `br_taken = e_branch & cond & (state == RUN)`.
- Squash FSM states: RUN, SQ(k) for k = SQUASH_N..1.
  - RUN goes to SQ(SQUASH_N) when `br_taken`, otherwise stays in RUN.
  - SQ(k) goes to SQ(k-1); SQ(1) goes to RUN.
  - Transitions are unconditional once squashing starts.
- In any SQ state the EXE instruction is a bubble:
  - `m_valid`, `m_wreg`, `m_m2reg`, `m_wmem` register 0.
  - `br_taken` is 0, even if the squashed instruction is itself a taken branch.
  - `m_alu`, `m_data_b`, `m_rd` and the trace tags still register their computed values, for debug only.
- The taken branch itself registers normally with `m_valid = 1`; its `m_wreg`/`m_wmem` are whatever ID supplied (normally 0).
- `m_rd = e_regrt ? e_rt : e_rd`.
- Reset, asserted at any time including mid-squash:
  - FSM returns to RUN.
  - All registered outputs are 0.
  - `br_taken` is 0 while `rst_n` is low.

## Timing
- `br_taken` and `br_target` are combinational from the ID/EXE outputs in the same cycle. The PC loads `br_target` at the next edge.
- All `m_*` and `MEM_*` outputs have 1-cycle latency.
- After a taken branch at edge t, the instructions in EXE during cycles t+1..t+SQUASH_N are squashed. The first correct-path instruction executes in cycle t+SQUASH_N+1.
- There are no stalls, no back-pressure, and no handshake. The block accepts one instruction per cycle.
- Back-to-back branches: the second branch falls in a squash slot and is ignored; no double redirect occurs.

## Structure
- Package `cpu_pkg`:
  - ALUC code constants.
  - Squash state enum.
  - Shift-amount field bounds `[10:6]`.
- Sub-module `alu`: combinational; inputs `a`, `b`, `aluc`; outputs `result`, `zero`; reusable elsewhere.
- `exe_stage` holds operand muxes, branch logic, the FSM and the EXE/MEM register.

## Test plan
- Reset: hold `rst_n` low, drive `ewreg = 1` and ADD → all `m_*` = 0, `br_taken` = 0. Release reset → next edge `m_valid` = 1.
- ALU: ADD 0xFFFFFFFF + 1 → `m_alu` = 0. SLT -1 < 1 → 1. SRA 0x80000000 by 4 → 0xF8000000. LUI imm 0x1234 → 0x12340000.
- BEQ taken: `a = b = 5`, `e_pc4 = 0x100`, imm = -2 → `br_taken` = 1, `br_target` = 0xF8. The next 2 instructions (`ewreg = 1`) → `m_valid`/`m_wreg` = 0. The third → `m_wreg` = 1.
- BNE not taken with `a == b` → `br_taken` = 0 and no squash.
- Squashed slot holds a taken BEQ → `br_taken` = 0. The FSM returns to RUN after exactly SQUASH_N cycles.
- Assert `rst_n` low during SQ(1) → after release, the FSM is in RUN and the first instruction is not squashed.
